fifo_push_arbiter: RTL and testbench
====================================

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: MAX_PKT, default 16, maximum payload bytes per grant (legal range 1..255).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-low reset.
REQ-005 Ports: req0_valid / req1_valid  input  1  requester N offers a byte.
REQ-006 Ports: req0_data / req1_data  input  8  requester N byte.
REQ-007 Ports: req0_last / req1_last  input  1  marks the final byte of the packet.
REQ-008 Ports: req0_ready / req1_ready  output  1  byte from requester N accepted this cycle.
REQ-009 Port: fifo_full  input  1  full flag of the downstream 64x8 FIFO.
REQ-010 Port: fifo_push  output  1  push strobe to the FIFO.
REQ-011 Port: fifo_push_data  output  8  byte to the FIFO.
REQ-012 Port: grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, HDR and XFER; HDR is reachable only when HDR_EN is defined.
REQ-015 In IDLE with exactly one reqN_valid high, the block SHALL register grant to N and move to XFER (or HDR) next cycle.
REQ-016 In IDLE with both valid, the block SHALL grant the requester opposite to the last served one (round-robin pointer).
REQ-017 In IDLE, ready, fifo_push and grant SHALL all be 0.
REQ-018 In XFER, the owner's ready SHALL equal ~fifo_full (combinational), and the non-owner's ready SHALL be 0.
REQ-019 In XFER, fifo_push SHALL equal owner_valid & ~fifo_full, and fifo_push_data SHALL equal the owner's data.
REQ-020 A byte SHALL transfer only when owner_valid & ready; fifo_push SHALL never be high while fifo_full=1.
REQ-021 An 8-bit payload counter SHALL increment per transferred byte.
REQ-022 A transfer with last=1, or with counter==MAX_PKT-1, SHALL end the grant: next state IDLE, counter cleared, round-robin pointer set to the other requester.
REQ-023 Truncation at MAX_PKT SHALL NOT wait for last; the owner's remaining bytes are then arbitrated as a new packet.
REQ-024 If owner_valid drops mid-packet, the block SHALL hold the grant and counter indefinitely.
REQ-025 Latency SHALL be: first payload push at earliest 1 cycle after valid is sampled in IDLE (2 cycles with HDR_EN); throughput 1 byte/cycle while not full.
REQ-026 Return from the end of a packet to IDLE SHALL cost one dead cycle before the next grant.

Reset
REQ-027 While rst=0 at a clock edge, the block SHALL set state=IDLE, grant=0, counter=0, and round-robin pointer favouring req0.
REQ-028 During and after reset, busy, fifo_push, both ready and fifo_push_data (8'h00) SHALL be 0.
REQ-029 Reset mid-packet SHALL abandon the packet; no push occurs in the cycle following reset assertion.

Configuration
REQ-030 With macro FIFO_ARB_HDR_EN defined, each grant SHALL first pass through HDR.
REQ-031 In HDR, the block SHALL push header byte 8'hA0|N when ~fifo_full, with ready held 0, then go to XFER; the header SHALL NOT count toward MAX_PKT.
REQ-032 Without FIFO_ARB_HDR_EN, HDR and its logic SHALL be absent, and the flow SHALL be IDLE->XFER directly.

Verification
REQ-033 Single packet: req0 sends 0x11,0x22,0x33 (last on 0x33), FIFO empty -> pushes 0x11,0x22,0x33 on consecutive cycles; grant=01; busy falls the cycle after 0x33.
REQ-034 Contention: both valid from reset -> req0 packet fully pushed first, then req1; with both still valid, next grant goes to req0 again (alternation).
REQ-035 Backpressure: fifo_full=1 for 5 cycles mid-packet -> fifo_push=0 and ready=0 those cycles; no byte lost or duplicated; order preserved.
REQ-036 Truncation: MAX_PKT=4, req1 streams 6 bytes with last only on byte 6 -> grant ends after byte 4; bytes 5-6 pushed under a new grant.
REQ-037 Reset mid-packet: rst=0 after 2 of 5 bytes -> next cycle grant=0, fifo_push=0, busy=0; after release, a fresh req0 packet starts at counter 0.
REQ-038 HDR_EN build: req1 sends 0x55 (last) -> FIFO receives 0xA1 then 0x55; req1_ready is low during the header cycle.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Two-requester packet arbiter feeding a downstream byte FIFO with round-robin grants.
// Optional header insertion per grant is enabled by defining FIFO_ARB_HDR_EN.
module fifo_push_arbiter #(
  parameter int unsigned MAX_PKT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       fifo_full,
  output logic       fifo_push,
  output logic [7:0] fifo_push_data,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1
`ifdef FIFO_ARB_HDR_EN
    ,
    ST_HDR  = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;   // requester favoured on a tie (0 = req0)
  logic             pick1;

  logic       owner;
  logic       owner_valid;
  logic [7:0] owner_data;
  logic       owner_last;

  assign owner       = grant_q[1];
  assign owner_valid = owner ? req1_valid : req0_valid;
  assign owner_data  = owner ? req1_data  : req0_data;
  assign owner_last  = owner ? req1_last  : req0_last;

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    pick1   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          pick1   = (req0_valid && req1_valid) ? rr_q : req1_valid;
          grant_d = pick1 ? 2'b10 : 2'b01;
`ifdef FIFO_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef FIFO_ARB_HDR_EN
      ST_HDR: begin
        if (!fifo_full) state_d = ST_XFER;
      end
`endif
      ST_XFER: begin
        if (owner_valid && !fifo_full) begin
          if (owner_last || (cnt_q == CNT_LAST)) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            cnt_d   = '0;
            rr_d    = ~owner;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake and FIFO outputs follow the owner combinationally
  always_comb begin
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    fifo_push      = 1'b0;
    fifo_push_data = 8'h00;
    case (state_q)
`ifdef FIFO_ARB_HDR_EN
      ST_HDR: begin
        fifo_push      = ~fifo_full;
        fifo_push_data = 8'hA0 | 8'(owner);
      end
`endif
      ST_XFER: begin
        req0_ready     = ~owner & ~fifo_full;
        req1_ready     = owner & ~fifo_full;
        fifo_push      = owner_valid & ~fifo_full;
        fifo_push_data = owner_data;
      end
      default: begin
        fifo_push_data = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter (MAX_PKT=4): reset, single packet, contention,
// backpressure, truncation, mid-packet reset, and header insertion when FIFO_ARB_HDR_EN is set.
module tb_fifo_push_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       fifo_full, fifo_push;
  logic [7:0] fifo_push_data;
  logic [1:0] grant;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [7:0] got[$];
  logic [1:0] gq[$];
  logic       full_i = 1'b0;

  logic       s_push, s_r0, s_r1, s_busy;
  logic [7:0] s_data;
  logic [1:0] s_grant;

  fifo_push_arbiter #(.MAX_PKT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_push_data(fifo_push_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock: drive from source queues at negedge, sample mid-cycle, retire accepted bytes
  task automatic tick();
    req0_valid = (src0.size() != 0);
    {req0_last, req0_data} = req0_valid ? src0[0] : 9'h000;
    req1_valid = (src1.size() != 0);
    {req1_last, req1_data} = req1_valid ? src1[0] : 9'h000;
    fifo_full = full_i;
    #2;
    s_push = fifo_push; s_data = fifo_push_data; s_grant = grant;
    s_busy = busy; s_r0 = req0_ready; s_r1 = req1_ready;
    if (fifo_push) begin
      got.push_back(fifo_push_data);
      gq.push_back(grant);
    end
    if (fifo_push && fifo_full) viol++;
    if (req0_valid && req0_ready) void'(src0.pop_front());
    if (req1_valid && req1_ready) void'(src1.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    src0.delete(); src1.delete();
    full_i = 1'b0;
    tick();
    rst = 1'b1;
    got.delete(); gq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    src0 = '{9'h0AA};
    tick();
    tick();
    total++; if (s_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", s_push); end
    total++; if (s_r0 !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", s_r0); end
    total++; if (s_r1 !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b exp=0", s_r1); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    total++; if (s_grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", s_grant); end
    total++; if (s_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", s_data); end
    src0.delete();
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] ed [5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic       ep [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] eg [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    src0 = '{9'h011, 9'h022, 9'h133};
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if ({s_push, s_busy, s_grant, s_data} !== {ep[k], ep[k], eg[k], ed[k]}) begin
        bad++;
        $display("FAIL single[%0d] got push=%b busy=%b grant=%b data=%h exp push=%b busy=%b grant=%b data=%h",
                 k, s_push, s_busy, s_grant, s_data, ep[k], ep[k], eg[k], ed[k]);
      end
    end
  endtask

  task automatic test_contention();
    logic [7:0] ed [7] = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83};
    logic [1:0] eg [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
    int n = 0;
    do_reset();
    src0 = '{9'h001, 9'h102, 9'h003, 9'h104};
    src1 = '{9'h081, 9'h182, 9'h183};
    for (int k = 0; k < 40 && (src0.size() != 0 || src1.size() != 0); k++) begin
      tick();
      n++;
      if (s_grant == 2'b01) begin
        total++; if (s_r1 !== 1'b0) begin bad++; $display("FAIL cont_nonowner_ready1[%0d] got=%b exp=0", k, s_r1); end
      end
    end
    total++; if (n !== 11) begin bad++; $display("FAIL cont_cycles got=%0d exp=11", n); end
    total++; if (got.size() !== 7) begin bad++; $display("FAIL cont_count got=%0d exp=7", got.size()); end
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      total++;
      if ({gq[i], got[i]} !== {eg[i], ed[i]}) begin
        bad++;
        $display("FAIL cont_byte[%0d] got grant=%b data=%h exp grant=%b data=%h", i, gq[i], got[i], eg[i], ed[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    do_reset();
    viol = 0;
    src0 = '{9'h010, 9'h020, 9'h030, 9'h140};
    for (int k = 0; k < 10; k++) begin
      full_i = (k >= 2 && k <= 6);
      tick();
      if (k >= 2 && k <= 6) begin
        total++;
        if ({s_push, s_r0} !== 2'b00) begin
          bad++;
          $display("FAIL bp_stall[%0d] got push=%b ready=%b exp push=0 ready=0", k, s_push, s_r0);
        end
      end
    end
    full_i = 1'b0;
    total++; if (viol !== 0) begin bad++; $display("FAIL bp_push_while_full got=%0d exp=0", viol); end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== ed[i]) begin bad++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got[i], ed[i]); end
    end
  endtask

  task automatic test_trunc();
    logic [7:0] ed [6] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    logic       bz [8];
    int n = 0;
    do_reset();
    src1 = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4, 9'h0C5, 9'h1C6};
    for (int k = 0; k < 20 && src1.size() != 0; k++) begin
      tick();
      if (k < 8) bz[k] = s_busy;
      n++;
    end
    total++; if (n !== 8) begin bad++; $display("FAIL trunc_cycles got=%0d exp=8", n); end
    total++; if (bz[5] !== 1'b0) begin bad++; $display("FAIL trunc_idle_gap got=%b exp=0", bz[5]); end
    total++; if (got.size() !== 6) begin bad++; $display("FAIL trunc_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      total++;
      if ({gq[i], got[i]} !== {2'b10, ed[i]}) begin
        bad++;
        $display("FAIL trunc_byte[%0d] got grant=%b data=%h exp grant=10 data=%h", i, gq[i], got[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ed [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    logic       bz [8];
    do_reset();
    src0 = '{9'h051, 9'h052, 9'h053, 9'h054, 9'h155};
    tick(); tick(); tick();
    total++; if (got.size() !== 2) begin bad++; $display("FAIL rmid_pre_count got=%0d exp=2", got.size()); end
    rst = 1'b0;
    src0.delete();
    tick();
    rst = 1'b1;
    tick();
    total++; if (s_grant !== 2'b00) begin bad++; $display("FAIL rmid_grant got=%b exp=00", s_grant); end
    total++; if (s_push !== 1'b0) begin bad++; $display("FAIL rmid_push got=%b exp=0", s_push); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", s_busy); end
    got.delete(); gq.delete();
    src0 = '{9'h061, 9'h062, 9'h063, 9'h064, 9'h065, 9'h166};
    for (int k = 0; k < 8; k++) begin
      tick();
      bz[k] = s_busy;
    end
    total++; if (bz[5] !== 1'b0) begin bad++; $display("FAIL rmid_fresh_trunc got=%b exp=0", bz[5]); end
    total++; if (got.size() !== 6) begin bad++; $display("FAIL rmid_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== ed[i]) begin bad++; $display("FAIL rmid_byte[%0d] got=%h exp=%h", i, got[i], ed[i]); end
    end
  endtask

  task automatic test_hdr();
    do_reset();
    src1 = '{9'h155};
    tick();
    total++; if (s_push !== 1'b0) begin bad++; $display("FAIL hdr_idle_push got=%b exp=0", s_push); end
    tick();
    total++; if ({s_push, s_data} !== {1'b1, 8'hA1}) begin bad++; $display("FAIL hdr_header got push=%b data=%h exp push=1 data=a1", s_push, s_data); end
    total++; if (s_r1 !== 1'b0) begin bad++; $display("FAIL hdr_ready1 got=%b exp=0", s_r1); end
    tick();
    total++; if ({s_push, s_data} !== {1'b1, 8'h55}) begin bad++; $display("FAIL hdr_payload got push=%b data=%h exp push=1 data=55", s_push, s_data); end
    tick();
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL hdr_end_busy got=%b exp=0", s_busy); end
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
`ifdef FIFO_ARB_HDR_EN
    test_hdr();
`else
    test_single();
    test_contention();
    test_backpressure();
    test_trunc();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
